// File: rtl/ps2_rx_scancode.sv
// PS/2 keyboard receiver: synchronises and deglitches the pins, deframes 11-bit
// frames with odd parity, and forwards only make codes to the command decoder.
`timescale 1ns/1ps

module ps2_rx_scancode #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       listo,
    output logic       parity_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic                    r_clkMeta;
    logic                    r_clkSync;
    logic                    r_dataMeta;
    logic                    r_dataSync;
    logic [FILTER_LEN-1:0]   r_clkShift;
    logic                    r_clkFilt;
    logic                    w_fall;
    logic [2:0]              r_bitCnt;
    logic [7:0]              r_shift;
    logic                    r_parity;
    logic [WD_W-1:0]         r_wdCnt;
    logic                    w_timeout;
    logic                    w_byteValid;
    logic                    w_frameErr;
    logic                    r_brk;
    logic                    r_ext;
    logic                    w_brkNext;
    logic                    w_extNext;
    logic                    w_emit;
    logic [7:0]              r_keyCode;
    logic                    r_listo;
    logic                    r_parErr;

    // Both pins idle high, so synchronisers and filter come out of reset at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkMeta  <= 1'b1;
            r_clkSync  <= 1'b1;
            r_dataMeta <= 1'b1;
            r_dataSync <= 1'b1;
            r_clkShift <= '1;
            r_clkFilt  <= 1'b1;
        end else begin
            r_clkMeta  <= ps2_clk;
            r_clkSync  <= r_clkMeta;
            r_dataMeta <= ps2_data;
            r_dataSync <= r_dataMeta;
            r_clkShift <= {r_clkShift[FILTER_LEN-2:0], r_clkSync};
            if (&r_clkShift) begin
                r_clkFilt <= 1'b1;
            end else if (~|r_clkShift) begin
                r_clkFilt <= 1'b0;
            end
        end
    end

    assign w_fall = r_clkFilt & ~(|r_clkShift);

    always_comb begin
        w_stateNext = r_state;
        w_byteValid = 1'b0;
        w_frameErr  = 1'b0;
        w_timeout   = (r_state != S_IDLE) && (r_wdCnt == WD_W'(TIMEOUT_CYC - 1));
        if (w_timeout) begin
            w_stateNext = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dataSync) w_stateNext = S_DATA;
                S_DATA:   if (r_bitCnt == 3'd7) w_stateNext = S_PARITY;
                S_PARITY: w_stateNext = S_STOP;
                S_STOP: begin
                    w_stateNext = S_IDLE;
                    if (r_dataSync && (^{r_shift, r_parity})) begin
                        w_byteValid = 1'b1;
                    end else begin
                        w_frameErr = 1'b1;
                    end
                end
                default:  w_stateNext = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bitCnt <= 3'd0;
            r_shift  <= 8'h00;
            r_parity <= 1'b0;
            r_wdCnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            if ((r_state == S_IDLE) || w_fall) begin
                r_wdCnt <= '0;
            end else begin
                r_wdCnt <= r_wdCnt + 1'b1;
            end
            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bitCnt <= 3'd0;
                    S_DATA: begin
                        r_shift  <= {r_dataSync, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                    end
                    S_PARITY: r_parity <= r_dataSync;
                    default:  ;
                endcase
            end
        end
    end

    // Prefix bytes only update flags; a break sequence swallows the release code.
    always_comb begin
        w_brkNext = r_brk;
        w_extNext = r_ext;
        w_emit    = 1'b0;
        if (w_byteValid) begin
            if (r_shift == 8'hF0) begin
                w_brkNext = 1'b1;
            end else if (r_shift == 8'hE0) begin
                w_extNext = 1'b1;
            end else if (r_brk) begin
                w_brkNext = 1'b0;
                w_extNext = 1'b0;
            end else begin
                w_extNext = 1'b0;
                w_emit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_keyCode <= 8'h00;
            r_listo   <= 1'b0;
            r_parErr  <= 1'b0;
        end else begin
            r_brk    <= w_brkNext;
            r_ext    <= w_extNext;
            r_listo  <= w_emit;
            r_parErr <= w_frameErr;
            if (w_emit) begin
                r_keyCode <= r_shift;
            end
        end
    end

    assign key_code   = r_keyCode;
    assign listo      = r_listo;
    assign parity_err = r_parErr;

endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Self-checking bench for ps2_rx_scancode: directed frames plus a random
// make/break/extended stream compared against a frame-level reference model.
`timescale 1ns/1ps

module tb_ps2_rx_scancode;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 600;
    localparam int HALF        = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       listo;
    logic       parity_err;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    int listoCount     = 0;
    int errCount       = 0;
    int lastPulseCycle = 0;
    int widthErr       = 0;
    int keyGlitch      = 0;
    logic       prevListo = 1'b0;
    logic       prevErr   = 1'b0;
    logic [7:0] prevKey   = 8'h00;

    int         expListo      = 0;
    int         expErr        = 0;
    logic [7:0] expKey        = 8'h00;
    bit         mBrk          = 1'b0;
    bit         mExt          = 1'b0;
    int         stopFallCycle = 0;

    ps2_rx_scancode #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code  (key_code),
        .listo     (listo),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Pulse monitor: counts pulses, flags pulses wider than one cycle and any
    // key_code change that is not accompanied by listo.
    always @(negedge clk) begin
        if (reset) begin
            prevListo = 1'b0;
            prevErr   = 1'b0;
            prevKey   = key_code;
        end else begin
            if (listo) begin
                listoCount++;
                lastPulseCycle = cycle;
                if (prevListo) widthErr++;
            end
            if (parity_err) begin
                errCount++;
                lastPulseCycle = cycle;
                if (prevErr) widthErr++;
            end
            if ((key_code != prevKey) && !listo) keyGlitch++;
            prevListo = listo;
            prevErr   = parity_err;
            prevKey   = key_code;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Drives the first nBits bits of an 11-bit frame; the clock is low for lowCyc cycles per bit.
    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit stopBit,
                                 input int nBits, input int lowCyc, input int highCyc);
        logic [10:0] frame;
        frame = {stopBit, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nBits; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            repeat (highCyc / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) stopFallCycle = cycle;
            repeat (lowCyc) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (highCyc - highCyc / 2) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic modelFrame(input logic [7:0] b, input bit badPar, input bit stopBit);
        if (badPar || !stopBit) begin
            expErr++;
        end else if (b == 8'hF0) begin
            mBrk = 1'b1;
        end else if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (mBrk) begin
            mBrk = 1'b0;
            mExt = 1'b0;
        end else begin
            expKey = b;
            expListo++;
            mExt = 1'b0;
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit stopBit,
                             input int lowCyc, input int highCyc, input string tag);
        int pulsesBefore;
        int lat;
        pulsesBefore = expListo + expErr;
        applyStimulus(b, badPar, stopBit, 11, lowCyc, highCyc);
        modelFrame(b, badPar, stopBit);
        repeat (FILTER_LEN + 10) @(negedge clk);
        checkOutput({tag, ".listoCount"}, listoCount, expListo);
        checkOutput({tag, ".errCount"}, errCount, expErr);
        checkOutput({tag, ".keyCode"}, int'(key_code), int'(expKey));
        if (expListo + expErr != pulsesBefore) begin
            lat = lastPulseCycle - stopFallCycle;
            checkOutput({tag, ".latencyOk"}, int'(lat >= 1 && lat <= FILTER_LEN + 4), 1);
        end
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset.keyCode", int'(key_code), 0);
        checkOutput("reset.listo", int'(listo), 0);
        checkOutput("reset.parityErr", int'(parity_err), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        sendFrame(8'h1D, 1'b0, 1'b1, HALF, HALF, "make1D");
        sendFrame(8'hF0, 1'b0, 1'b1, HALF, HALF, "brkF0");
        sendFrame(8'h1D, 1'b0, 1'b1, HALF, HALF, "brk1D");

        sendFrame(8'h24, 1'b1, 1'b1, HALF, HALF, "badPar24");
        sendFrame(8'h2B, 1'b0, 1'b1, HALF, HALF, "make2B");
        sendFrame(8'h33, 1'b0, 1'b0, HALF, HALF, "badStop33");

        applyStimulus(8'h55, 1'b0, 1'b1, 5, HALF, HALF);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        checkOutput("timeout.listoCount", listoCount, expListo);
        checkOutput("timeout.errCount", errCount, expErr);
        sendFrame(8'h4D, 1'b0, 1'b1, HALF, HALF, "after4D");

        sendFrame(8'hE0, 1'b0, 1'b1, HALF, HALF, "extE0");
        sendFrame(8'h75, 1'b0, 1'b1, HALF, HALF, "ext75");
        sendFrame(8'hE0, 1'b0, 1'b1, HALF, HALF, "extE0b");
        sendFrame(8'hF0, 1'b0, 1'b1, HALF, HALF, "extF0");
        sendFrame(8'h75, 1'b0, 1'b1, HALF, HALF, "extRel75");

        // Short low pulse with data low: if it were taken as a start bit the next frame would misalign.
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
        sendFrame(8'h5A, 1'b0, 1'b1, HALF, HALF, "glitch5A");
        sendFrame(8'h3C, 1'b0, 1'b1, FILTER_LEN, HALF, "minLow3C");

        sendFrame(8'hF0, 1'b0, 1'b1, HALF, HALF, "preRstF0");
        applyStimulus(8'h66, 1'b0, 1'b1, 6, HALF, HALF);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midReset.keyCode", int'(key_code), 0);
        checkOutput("midReset.listo", int'(listo), 0);
        checkOutput("midReset.parityErr", int'(parity_err), 0);
        expKey = 8'h00;
        mBrk   = 1'b0;
        mExt   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        sendFrame(8'h1C, 1'b0, 1'b1, HALF, HALF, "postRst1C");

        for (int n = 0; n < 30; n++) begin
            logic [7:0] b;
            int         sel;
            int         half;
            sel  = $urandom_range(0, 9);
            b    = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
            half = $urandom_range(20, 50);
            sendFrame(b, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) != 0),
                      half, half, "rand");
        end

        checkOutput("pulseWidth", widthErr, 0);
        checkOutput("keyStable", keyGlitch, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
